// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order tracking buffer, 2 allocs / 3 completions / 2 retires per cycle.
// Optional feature macro: ROB_FLUSH_EN (adds input flush: clears the whole buffer at the edge).
//
// Ports:
//   clk, reset                  clock; asynchronous active-high reset
//   flush                       (ROB_FLUSH_EN only) clear all entries, pointers and count
//   disp_valid_a/b              allocation requests, A older than B
//   disp_has_dest_a/b           instruction writes a register
//   disp_old_a/b                previous physical mapping, freed at retire
//   disp_pc_a/b                 instruction PC
//   disp_ready                  at least two free entries (registered count only)
//   disp_rob_a/b                indices assigned to A / B this cycle
//   cmp_valid, cmp_rob          three completion ports, packed indices
//   ret_valid_a/b               head / head+1 retiring this cycle
//   ret_free_valid_a/b          retiring instruction had a destination
//   ret_free_a/b, ret_pc_a/b    register to free and PC of the retiring instruction
//   rob_count, rob_empty        occupancy
module reorder_buffer #(
    parameter int ROB_SIZE_BITS = 4,
    parameter int PREG_BITS     = 6,
    parameter int PC_W          = 32
) (
    input  logic                       clk,
    input  logic                       reset,
`ifdef ROB_FLUSH_EN
    input  logic                       flush,
`endif
    input  logic                       disp_valid_a,
    input  logic                       disp_valid_b,
    input  logic                       disp_has_dest_a,
    input  logic                       disp_has_dest_b,
    input  logic [PREG_BITS-1:0]       disp_old_a,
    input  logic [PREG_BITS-1:0]       disp_old_b,
    input  logic [PC_W-1:0]            disp_pc_a,
    input  logic [PC_W-1:0]            disp_pc_b,
    output logic                       disp_ready,
    output logic [ROB_SIZE_BITS-1:0]   disp_rob_a,
    output logic [ROB_SIZE_BITS-1:0]   disp_rob_b,
    input  logic [2:0]                 cmp_valid,
    input  logic [3*ROB_SIZE_BITS-1:0] cmp_rob,
    output logic                       ret_valid_a,
    output logic                       ret_valid_b,
    output logic                       ret_free_valid_a,
    output logic                       ret_free_valid_b,
    output logic [PREG_BITS-1:0]       ret_free_a,
    output logic [PREG_BITS-1:0]       ret_free_b,
    output logic [PC_W-1:0]            ret_pc_a,
    output logic [PC_W-1:0]            ret_pc_b,
    output logic [ROB_SIZE_BITS:0]     rob_count,
    output logic                       rob_empty
);
    localparam int RB = ROB_SIZE_BITS;
    localparam int N  = 1 << RB;
    localparam logic [RB:0] CNT_LIM = (RB+1)'(N - 2);

    logic [N-1:0]         r_busy;
    logic [N-1:0]         r_done;
    logic [N-1:0]         r_has_dest;
    logic [PREG_BITS-1:0] r_old [N];
    logic [PC_W-1:0]      r_pc  [N];
    logic [RB:0]          r_head;
    logic [RB:0]          r_tail;
    logic [RB:0]          r_count;

    logic          w_flush;
    logic          w_ready;
    logic          w_alloc_a;
    logic          w_alloc_b;
    logic [RB-1:0] w_idx_a;
    logic [RB-1:0] w_idx_b;
    logic [RB-1:0] w_h0;
    logic [RB-1:0] w_h1;
    logic          w_ret_a;
    logic          w_ret_b;
    logic [RB:0]   w_n_disp;
    logic [RB:0]   w_n_ret;

`ifdef ROB_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    // Readiness looks only at the registered count, never at same-cycle retires.
    assign w_ready   = (r_count <= CNT_LIM) & ~w_flush;
    assign w_alloc_a = w_ready & disp_valid_a;
    assign w_alloc_b = w_ready & disp_valid_b;
    assign w_idx_a   = r_tail[RB-1:0];
    assign w_idx_b   = r_tail[RB-1:0] + RB'(disp_valid_a);

    assign w_h0    = r_head[RB-1:0];
    assign w_h1    = w_h0 + RB'(1);
    assign w_ret_a = r_busy[w_h0] & r_done[w_h0] & ~w_flush;
    assign w_ret_b = w_ret_a & r_busy[w_h1] & r_done[w_h1];

    assign w_n_disp = (RB+1)'(w_alloc_a) + (RB+1)'(w_alloc_b);
    assign w_n_ret  = (RB+1)'(w_ret_a) + (RB+1)'(w_ret_b);

    assign disp_ready = w_ready;
    assign disp_rob_a = w_idx_a;
    assign disp_rob_b = w_idx_b;

    // Payload is masked so idle retire outputs read as zero.
    assign ret_valid_a      = w_ret_a;
    assign ret_valid_b      = w_ret_b;
    assign ret_free_valid_a = w_ret_a & r_has_dest[w_h0];
    assign ret_free_valid_b = w_ret_b & r_has_dest[w_h1];
    assign ret_free_a       = w_ret_a ? r_old[w_h0] : '0;
    assign ret_free_b       = w_ret_b ? r_old[w_h1] : '0;
    assign ret_pc_a         = w_ret_a ? r_pc[w_h0] : '0;
    assign ret_pc_b         = w_ret_b ? r_pc[w_h1] : '0;

    assign rob_count = r_count;
    assign rob_empty = (r_count == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy     <= '0;
            r_done     <= '0;
            r_has_dest <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else if (w_flush) begin
            r_busy  <= '0;
            r_done  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            // Order matters: completion, then retire clear, then allocation.
            // Allocated slots are never busy, so a same-cycle completion to them is dropped.
            for (int k = 0; k < 3; k++) begin
                if (cmp_valid[k] && r_busy[cmp_rob[k*RB +: RB]]) begin
                    r_done[cmp_rob[k*RB +: RB]] <= 1'b1;
                end
            end
            if (w_ret_a) begin
                r_busy[w_h0] <= 1'b0;
                r_done[w_h0] <= 1'b0;
            end
            if (w_ret_b) begin
                r_busy[w_h1] <= 1'b0;
                r_done[w_h1] <= 1'b0;
            end
            if (w_alloc_a) begin
                r_busy[w_idx_a]     <= 1'b1;
                r_done[w_idx_a]     <= 1'b0;
                r_has_dest[w_idx_a] <= disp_has_dest_a;
            end
            if (w_alloc_b) begin
                r_busy[w_idx_b]     <= 1'b1;
                r_done[w_idx_b]     <= 1'b0;
                r_has_dest[w_idx_b] <= disp_has_dest_b;
            end
            r_head  <= r_head + w_n_ret;
            r_tail  <= r_tail + w_n_disp;
            r_count <= r_count + w_n_disp - w_n_ret;
        end
    end

    // Payload fields need no reset: they are only observed behind busy/done.
    always_ff @(posedge clk) begin
        if (w_alloc_a) begin
            r_old[w_idx_a] <= disp_old_a;
            r_pc[w_idx_a]  <= disp_pc_a;
        end
        if (w_alloc_b) begin
            r_old[w_idx_b] <= disp_old_b;
            r_pc[w_idx_b]  <= disp_pc_b;
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed checks of reorder_buffer allocation, completion, retire and wrap.
// A small reference model tracks the streaming phase; define ROB_FLUSH_EN to exercise flush.
module tb_reorder_buffer;
    localparam int RB = 4;
    localparam int PB = 6;
    localparam int PW = 32;
    localparam int N  = 16;

    logic          clk = 1'b0;
    logic          reset;
`ifdef ROB_FLUSH_EN
    logic          flush;
`endif
    logic          disp_valid_a, disp_valid_b;
    logic          disp_has_dest_a, disp_has_dest_b;
    logic [PB-1:0] disp_old_a, disp_old_b;
    logic [PW-1:0] disp_pc_a, disp_pc_b;
    logic          disp_ready;
    logic [RB-1:0] disp_rob_a, disp_rob_b;
    logic [2:0]    cmp_valid;
    logic [3*RB-1:0] cmp_rob;
    logic          ret_valid_a, ret_valid_b;
    logic          ret_free_valid_a, ret_free_valid_b;
    logic [PB-1:0] ret_free_a, ret_free_b;
    logic [PW-1:0] ret_pc_a, ret_pc_b;
    logic [RB:0]   rob_count;
    logic          rob_empty;

    reorder_buffer #(.ROB_SIZE_BITS(RB), .PREG_BITS(PB), .PC_W(PW)) dut (
        .clk              (clk),
        .reset            (reset),
`ifdef ROB_FLUSH_EN
        .flush            (flush),
`endif
        .disp_valid_a     (disp_valid_a),
        .disp_valid_b     (disp_valid_b),
        .disp_has_dest_a  (disp_has_dest_a),
        .disp_has_dest_b  (disp_has_dest_b),
        .disp_old_a       (disp_old_a),
        .disp_old_b       (disp_old_b),
        .disp_pc_a        (disp_pc_a),
        .disp_pc_b        (disp_pc_b),
        .disp_ready       (disp_ready),
        .disp_rob_a       (disp_rob_a),
        .disp_rob_b       (disp_rob_b),
        .cmp_valid        (cmp_valid),
        .cmp_rob          (cmp_rob),
        .ret_valid_a      (ret_valid_a),
        .ret_valid_b      (ret_valid_b),
        .ret_free_valid_a (ret_free_valid_a),
        .ret_free_valid_b (ret_free_valid_b),
        .ret_free_a       (ret_free_a),
        .ret_free_b       (ret_free_b),
        .ret_pc_a         (ret_pc_a),
        .ret_pc_b         (ret_pc_b),
        .rob_count        (rob_count),
        .rob_empty        (rob_empty)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        disp_valid_a    = 1'b0;
        disp_valid_b    = 1'b0;
        disp_has_dest_a = 1'b0;
        disp_has_dest_b = 1'b0;
        disp_old_a      = '0;
        disp_old_b      = '0;
        disp_pc_a       = '0;
        disp_pc_b       = '0;
        cmp_valid       = '0;
        cmp_rob         = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model for the streaming phase.
    bit [N-1:0]    m_busy;
    bit [N-1:0]    m_done;
    logic [RB:0]   m_head;
    logic [RB:0]   m_tail;
    int            m_count;
    logic [PW-1:0] next_pc;
    logic [RB-1:0] pend[$];
    logic [PW-1:0] exp_pc[$];

    task automatic step(input bit do_disp);
        logic [RB-1:0] ci [3];
        bit            cv [3];
        bit            rdy;
        bit            era;
        bit            erb;
        logic [RB-1:0] h0;
        logic [RB-1:0] h1;
        logic [RB-1:0] ta;
        idle();
        rdy = (m_count <= N - 2);
        if (do_disp) begin
            disp_valid_a    = 1'b1;
            disp_valid_b    = 1'b1;
            disp_has_dest_a = 1'b1;
            disp_has_dest_b = 1'b1;
            disp_old_a      = next_pc[7:2];
            disp_old_b      = next_pc[7:2] + 6'd1;
            disp_pc_a       = next_pc;
            disp_pc_b       = next_pc + 32'd4;
        end
        for (int k = 0; k < 3; k++) begin
            cv[k] = 1'b0;
            ci[k] = '0;
            if (pend.size() > 0) begin
                ci[k] = pend.pop_front();
                cv[k] = 1'b1;
                cmp_valid[k] = 1'b1;
                cmp_rob[k*RB +: RB] = ci[k];
            end
        end
        #1;
        chk("stream_ready", 64'(disp_ready), 64'(rdy));
        chk("stream_count", 64'(rob_count), 64'(m_count));
        ta = m_tail[RB-1:0];
        if (do_disp) begin
            chk("stream_rob_a", 64'(disp_rob_a), 64'(ta));
            chk("stream_rob_b", 64'(disp_rob_b), 64'(ta + 4'd1));
        end
        h0  = m_head[RB-1:0];
        h1  = h0 + 4'd1;
        era = m_busy[h0] & m_done[h0];
        erb = era & m_busy[h1] & m_done[h1];
        chk("stream_ret_a", 64'(ret_valid_a), 64'(era));
        chk("stream_ret_b", 64'(ret_valid_b), 64'(erb));
        if (era && exp_pc.size() > 0) chk("stream_pc_a", 64'(ret_pc_a), 64'(exp_pc[0]));
        if (erb && exp_pc.size() > 1) chk("stream_pc_b", 64'(ret_pc_b), 64'(exp_pc[1]));
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (cv[k] && m_busy[ci[k]]) m_done[ci[k]] = 1'b1;
        end
        if (era) begin
            m_busy[h0] = 1'b0;
            m_done[h0] = 1'b0;
            if (exp_pc.size() > 0) void'(exp_pc.pop_front());
            m_head  = m_head + 5'd1;
            m_count = m_count - 1;
        end
        if (erb) begin
            m_busy[h1] = 1'b0;
            m_done[h1] = 1'b0;
            if (exp_pc.size() > 0) void'(exp_pc.pop_front());
            m_head  = m_head + 5'd1;
            m_count = m_count - 1;
        end
        if (do_disp && rdy) begin
            m_busy[ta] = 1'b1;
            m_done[ta] = 1'b0;
            pend.push_back(ta);
            exp_pc.push_back(next_pc);
            m_busy[ta + 4'd1] = 1'b1;
            m_done[ta + 4'd1] = 1'b0;
            pend.push_back(ta + 4'd1);
            exp_pc.push_back(next_pc + 32'd4);
            m_tail  = m_tail + 5'd2;
            m_count = m_count + 2;
            next_pc = next_pc + 32'd8;
        end
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
`ifdef ROB_FLUSH_EN
        flush = 1'b0;
`endif
        reset = 1'b1;
        disp_valid_a = 1'b1;
        #1;
        chk("rst_empty", 64'(rob_empty), 64'(1));
        chk("rst_count", 64'(rob_count), 64'(0));
        chk("rst_ready", 64'(disp_ready), 64'(1));
        tick();
        tick();
        chk("rst_ret_a", 64'(ret_valid_a), 64'(0));
        chk("rst_ret_b", 64'(ret_valid_b), 64'(0));
        chk("rst_free_a", 64'(ret_free_a), 64'(0));
        chk("rst_pc_a", 64'(ret_pc_a), 64'(0));
        chk("rst_rob_a", 64'(disp_rob_a), 64'(0));
        chk("rst_rob_b", 64'(disp_rob_b), 64'(1));
        chk("rst_count2", 64'(rob_count), 64'(0));
        reset = 1'b0;
        disp_valid_a = 1'b0;
        tick();
        chk("idle_empty", 64'(rob_empty), 64'(1));
        chk("idle_ready", 64'(disp_ready), 64'(1));
        chk("idle_ret_a", 64'(ret_valid_a), 64'(0));

        // Pair A/B, complete younger first.
        disp_valid_a = 1'b1; disp_has_dest_a = 1'b1; disp_old_a = 6'd5; disp_pc_a = 32'h0;
        disp_valid_b = 1'b1; disp_has_dest_b = 1'b1; disp_old_b = 6'd7; disp_pc_b = 32'h4;
        #1;
        chk("pair_rob_a", 64'(disp_rob_a), 64'(0));
        chk("pair_rob_b", 64'(disp_rob_b), 64'(1));
        tick();
        idle();
        cmp_valid = 3'b001;
        cmp_rob = {4'd0, 4'd0, 4'd1};
        #1;
        chk("pair_count", 64'(rob_count), 64'(2));
        chk("pair_noret0", 64'(ret_valid_a), 64'(0));
        tick();
        idle();
        cmp_valid = 3'b100;
        cmp_rob = {4'd0, 4'd0, 4'd0};
        #1;
        chk("pair_noret1a", 64'(ret_valid_a), 64'(0));
        chk("pair_noret1b", 64'(ret_valid_b), 64'(0));
        tick();
        idle();
        #1;
        chk("pair_ret_a", 64'(ret_valid_a), 64'(1));
        chk("pair_ret_b", 64'(ret_valid_b), 64'(1));
        chk("pair_free_a", 64'(ret_free_a), 64'(5));
        chk("pair_free_b", 64'(ret_free_b), 64'(7));
        chk("pair_fv_a", 64'(ret_free_valid_a), 64'(1));
        chk("pair_fv_b", 64'(ret_free_valid_b), 64'(1));
        chk("pair_pc_b", 64'(ret_pc_b), 64'(4));
        chk("pair_count2", 64'(rob_count), 64'(2));
        tick();
        chk("pair_count0", 64'(rob_count), 64'(0));
        chk("pair_empty", 64'(rob_empty), 64'(1));

        // Fill: head = tail = 2; A has dest, B does not.
        for (int i = 0; i < 8; i++) begin
            disp_valid_a = 1'b1; disp_has_dest_a = 1'b1;
            disp_valid_b = 1'b1; disp_has_dest_b = 1'b0;
            disp_old_a = 6'(i);
            disp_old_b = 6'(32 + i);
            disp_pc_a = 32'(32'h100 + 8 * i);
            disp_pc_b = 32'(32'h104 + 8 * i);
            #1;
            if (i == 7) chk("fill_ready14", 64'(disp_ready), 64'(1));
            tick();
        end
        disp_pc_a = 32'h200;
        disp_pc_b = 32'h204;
        #1;
        chk("full_count", 64'(rob_count), 64'(16));
        chk("full_ready", 64'(disp_ready), 64'(0));
        chk("full_rob_a", 64'(disp_rob_a), 64'(2));
        tick();
        chk("full_ign_count", 64'(rob_count), 64'(16));
        chk("full_ign_rob_a", 64'(disp_rob_a), 64'(2));
        chk("full_ign_ret", 64'(ret_valid_a), 64'(0));

        // Complete head and head+1 while dispatch is still requested.
        cmp_valid = 3'b011;
        cmp_rob = {4'd0, 4'd3, 4'd2};
        #1;
        chk("fc_ready0", 64'(disp_ready), 64'(0));
        tick();
        cmp_valid = '0;
        cmp_rob = '0;
        #1;
        chk("fc_ret_a", 64'(ret_valid_a), 64'(1));
        chk("fc_ret_b", 64'(ret_valid_b), 64'(1));
        chk("fc_fv_a", 64'(ret_free_valid_a), 64'(1));
        chk("fc_free_a", 64'(ret_free_a), 64'(0));
        chk("fc_fv_b", 64'(ret_free_valid_b), 64'(0));
        chk("fc_pc_a", 64'(ret_pc_a), 64'(32'h100));
        chk("fc_pc_b", 64'(ret_pc_b), 64'(32'h104));
        chk("fc_ready_same", 64'(disp_ready), 64'(0));
        chk("fc_count16", 64'(rob_count), 64'(16));
        tick();
        idle();
        #1;
        chk("fc_count14", 64'(rob_count), 64'(14));
        chk("fc_ready_next", 64'(disp_ready), 64'(1));
        chk("fc_head_wait", 64'(ret_valid_a), 64'(0));

        // Hand the 14 remaining entries to the model, then stream with wrap.
        m_busy  = '0;
        m_done  = '0;
        m_head  = 5'd4;
        m_tail  = 5'd18;
        m_count = 14;
        next_pc = 32'h1000;
        for (int j = 0; j < 14; j++) begin
            m_busy[4'(4 + j)] = 1'b1;
            pend.push_back(4'(4 + j));
            exp_pc.push_back(32'(32'h108 + 4 * j));
        end
        for (int i = 0; i < 40; i++) step(1'b1);
        for (int i = 0; i < 80 && m_count != 0; i++) step(1'b0);
        chk("drain_count", 64'(rob_count), 64'(0));
        chk("drain_empty", 64'(rob_empty), 64'(1));
        chk("drain_sb", 64'(exp_pc.size()), 64'(0));

`ifdef ROB_FLUSH_EN
        begin
            logic [RB-1:0] h;
            h = m_tail[RB-1:0];
            for (int i = 0; i < 3; i++) begin
                idle();
                disp_valid_a = 1'b1; disp_has_dest_a = 1'b1;
                disp_valid_b = 1'b1; disp_has_dest_b = 1'b1;
                tick();
            end
            idle();
            cmp_valid = 3'b011;
            cmp_rob[3:0] = h;
            cmp_rob[7:4] = h + 4'd1;
            tick();
            idle();
            #1;
            chk("fl_pre_ret", 64'(ret_valid_a), 64'(1));
            chk("fl_pre_count", 64'(rob_count), 64'(6));
            flush = 1'b1;
            #1;
            chk("fl_ret_a", 64'(ret_valid_a), 64'(0));
            chk("fl_ret_b", 64'(ret_valid_b), 64'(0));
            chk("fl_ready", 64'(disp_ready), 64'(0));
            tick();
            flush = 1'b0;
            #1;
            chk("fl_count", 64'(rob_count), 64'(0));
            chk("fl_empty", 64'(rob_empty), 64'(1));
            chk("fl_rob_a", 64'(disp_rob_a), 64'(0));
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
